// File: rtl/apb_modport.sv
// apb_modport: an APB master bridge and two APB memory slaves behind a single
// request port.
//
// The master FSM has three states: IDLE, SETUP and ACCESS. Address bit AW-1
// selects the slave: 0 selects slave 1 and 1 selects slave 2. Each slave holds
// 2^(AW-1) words, and every word clears to zero on reset.
//
// Parameters:
//   AW                 address width (MSB = slave select)
//   DW                 data width
// Ports:
//   pclk               clock, rising edge
//   presetn            asynchronous active-low reset
//   transfer           request valid (hold high for back-to-back transfers)
//   read_write         1 = read, 0 = write
//   apb_write_paddr    write address
//   apb_write_data     write data
//   apb_read_paddr     read address
//   apb_read_data_out  data from the last completed read
//
// Optional feature, macro APB_WAIT_STATE_EN:
//   When defined, every slave inserts one wait state per ACCESS.
//   When undefined, pready is tied high.
module apb_modport #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out
);

    localparam int DEPTH = 1 << (AW - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e          state_q, state_d;
    logic            capture;
    logic            rw_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;

    // Internal APB bus
    logic            psel1, psel2, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata, prdata1, prdata2, prdata;
    logic            pready1, pready2, pready;

    logic [DW-1:0]   mem1_q [DEPTH];
    logic [DW-1:0]   mem2_q [DEPTH];

    assign pwrite  = ~rw_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;
    assign pready  = paddr[AW-1] ? pready2 : pready1;
    assign prdata  = paddr[AW-1] ? prdata2 : prdata1;
    assign prdata1 = mem1_q[paddr[AW-2:0]];
    assign prdata2 = mem2_q[paddr[AW-2:0]];

    assign apb_read_data_out = rdata_q;

    // ---------------- Master FSM ----------------
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        psel1   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SETUP;
                    capture = 1'b1;
                end
            end
            SETUP: begin
                psel1   = ~addr_q[AW-1];
                psel2   = addr_q[AW-1];
                state_d = ACCESS;
            end
            ACCESS: begin
                psel1   = ~addr_q[AW-1];
                psel2   = addr_q[AW-1];
                penable = 1'b1;
                if (pready) begin
                    if (transfer) begin
                        // Back-to-back: the next request is captured on the
                        // same edge that completes this transfer.
                        state_d = SETUP;
                        capture = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rw_q    <= read_write;
                addr_q  <= read_write ? apb_read_paddr : apb_write_paddr;
                wdata_q <= apb_write_data;
            end
            if (state_q == ACCESS && pready && rw_q) begin
                rdata_q <= prdata;
            end
        end
    end

    // ---------------- Slave memories ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem1_q[i] <= '0;
        end else if (psel1 && penable && pwrite && pready1) begin
            mem1_q[paddr[AW-2:0]] <= pwdata;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem2_q[i] <= '0;
        end else if (psel2 && penable && pwrite && pready2) begin
            mem2_q[paddr[AW-2:0]] <= pwdata;
        end
    end

`ifdef APB_WAIT_STATE_EN
    // Each wait flag goes high after the first ACCESS cycle and drops after
    // the second cycle completes the transfer, so pready is 0 and then 1.
    logic ws1_q, ws2_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ws1_q <= 1'b0;
            ws2_q <= 1'b0;
        end else begin
            ws1_q <= psel1 & penable & ~ws1_q;
            ws2_q <= psel2 & penable & ~ws2_q;
        end
    end

    assign pready1 = ws1_q;
    assign pready2 = ws2_q;
`else
    assign pready1 = 1'b1;
    assign pready2 = 1'b1;
`endif

endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport.
//
// Each read request pushes its expected data and its completion edge onto a
// scoreboard. On every falling edge, the monitor does one of two things:
//   - On the completion edge of the oldest entry, it pops that entry and
//     compares the read data.
//   - Otherwise it checks that the output is holding its last value.
module tb_apb_modport;

    localparam int AW = 9;
    localparam int DW = 8;
`ifdef APB_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          transfer = 1'b0;
    logic          read_write = 1'b0;
    logic [AW-1:0] apb_write_paddr = '0;
    logic [DW-1:0] apb_write_data = '0;
    logic [AW-1:0] apb_read_paddr = '0;
    logic [DW-1:0] apb_read_data_out;

    apb_modport #(.AW(AW), .DW(DW)) dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .read_write        (read_write),
        .apb_write_paddr   (apb_write_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_paddr    (apb_read_paddr),
        .apb_read_data_out (apb_read_data_out)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] model [1 << AW];
    logic [DW-1:0] last_exp = '0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    always @(posedge pclk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: compare read data on its due edge, otherwise check that it holds
    always @(negedge pclk) begin
        if (presetn) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                check_eq("rdata", apb_read_data_out, e.data);
                last_exp = e.data;
            end else begin
                check_eq("hold", apb_read_data_out, last_exp);
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
        last_exp = '0;
    endtask

    // Called at a falling edge when the DUT will capture on the next rising
    // edge. Returns at the falling edge where the next request can be
    // presented (keep=1), or with the DUT back in IDLE (keep=0).
    task automatic xfer(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
        transfer   = 1'b1;
        read_write = rd;
        if (rd) begin
            exp_t e;
            apb_read_paddr  = a;
            apb_write_paddr = ~a;
            apb_write_data  = ~d;
            e.data = model[a];
            e.due  = cyc + 3 + WS;
            sbq.push_back(e);
        end else begin
            apb_write_paddr = a;
            apb_read_paddr  = ~a;
            apb_write_data  = d;
            model[a] = d;
        end
        repeat (2 + WS) @(posedge pclk);
        @(negedge pclk);
        // Scramble the inputs mid-transfer; they must not affect it.
        apb_write_paddr = $urandom;
        apb_read_paddr  = $urandom;
        apb_write_data  = $urandom;
        read_write      = $urandom;
        if (!keep) begin
            transfer = 1'b0;
            @(posedge pclk);
            @(negedge pclk);
        end
    endtask

    task automatic do_reset();
        presetn  = 1'b0;
        transfer = 1'b0;
        repeat (2) @(negedge pclk);
        check_eq("reset_rdata", apb_read_data_out, 0);
        sbq.delete();
        clear_model();
        presetn = 1'b1;
    endtask

    initial begin
        clear_model();
        @(negedge pclk);
        do_reset();

        // Read of never-written location after reset
        xfer(1'b1, 9'h005, 8'h00, 1'b0);

        // Slave 1 write/read
        xfer(1'b0, 9'h010, 8'hA5, 1'b0);
        xfer(1'b1, 9'h010, 8'h00, 1'b0);

        // Slave decode: same low bits, different slave
        xfer(1'b0, 9'h110, 8'h3C, 1'b0);
        xfer(1'b0, 9'h010, 8'hC3, 1'b0);
        xfer(1'b1, 9'h110, 8'h00, 1'b0);
        xfer(1'b1, 9'h010, 8'h00, 1'b0);

        // Back-to-back writes then reads, transfer held high throughout
        xfer(1'b0, 9'h1FF, 8'h11, 1'b1);
        xfer(1'b0, 9'h000, 8'h22, 1'b1);
        xfer(1'b0, 9'h0FF, 8'h33, 1'b1);
        xfer(1'b0, 9'h100, 8'h44, 1'b1);
        xfer(1'b1, 9'h1FF, 8'h00, 1'b1);
        xfer(1'b1, 9'h000, 8'h00, 1'b1);
        xfer(1'b1, 9'h0FF, 8'h00, 1'b1);
        xfer(1'b1, 9'h100, 8'h00, 1'b1);
        // Read after write to same address in consecutive transfers
        xfer(1'b0, 9'h0AB, 8'h9E, 1'b1);
        xfer(1'b1, 9'h0AB, 8'h00, 1'b0);

        // Wait-state scenario address (latency follows the build)
        xfer(1'b0, 9'h101, 8'h5A, 1'b0);
        xfer(1'b1, 9'h101, 8'h00, 1'b0);

        // Reset during ACCESS of a write: the write must be lost
        transfer        = 1'b1;
        read_write      = 1'b0;
        apb_write_paddr = 9'h020;
        apb_write_data  = 8'h77;
        @(posedge pclk);
        @(posedge pclk);
        #1;
        presetn  = 1'b0;
        transfer = 1'b0;
        repeat (2) @(negedge pclk);
        check_eq("midreset_rdata", apb_read_data_out, 0);
        sbq.delete();
        clear_model();
        presetn = 1'b1;
        @(negedge pclk);
        xfer(1'b1, 9'h020, 8'h00, 1'b0);

        // Random mix, including back-to-back runs
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            a = (i % 2 == 1) ? 9'h1F0 + AW'($urandom_range(0, 3)) : 9'h0F0 + AW'($urandom_range(0, 3));
            xfer(1'($urandom), a, DW'($urandom), (i != 39) && ($urandom_range(0, 2) != 0));
        end

        // Drain the scoreboard with a bounded wait
        begin
            int budget;
            budget = 100;
            while (sbq.size() > 0 && budget > 0) begin
                @(negedge pclk);
                budget--;
            end
            check_eq("drain", sbq.size(), 0);
        end
        repeat (3) @(negedge pclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_modport.md
# apb_modport

Self-contained APB subsystem: one APB master bridge and two APB memory slaves behind a single request port. A simple transfer/read_write request side drives a three-state APB master FSM. The FSM decodes the address MSB to select slave 1 or slave 2, performs the write or read, and returns read data on a registered output. It is the design under test for the two-slave APB verification environment.

## Interface
- AW, 9: address width; bit AW-1 selects the slave, bits AW-2:0 address the slave memory.
- DW, 8: data width of the write and read data paths.
- pclk  in  1  system clock; all state updates on the rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- transfer  in  1  request valid; high means perform (or continue) APB transfers.
- read_write  in  1  1 = read, 0 = write; sampled with the request.
- apb_write_paddr  in  AW  write address; used when read_write=0.
- apb_write_data  in  DW  write data.
- apb_read_paddr  in  AW  read address; used when read_write=1.
- apb_read_data_out  out  DW  data returned by the last completed read.

## Operation
- Internal APB bus: psel1, psel2, penable, pwrite, paddr[AW-1:0], pwdata, prdata1/2, pready1/2.
- Master FSM states:
  - IDLE
    - psel=0, penable=0.
    - transfer=1 → SETUP.
  - SETUP
    - psel of the selected slave =1, penable=0.
    - Always → ACCESS next cycle.
  - ACCESS
    - psel=1, penable=1.
    - Selected pready=0 → stay in ACCESS.
    - pready=1 and transfer=1 → SETUP (back-to-back).
    - pready=1 and transfer=0 → IDLE.
- Request capture: read_write, the applicable address and apb_write_data are registered on every edge that enters SETUP. They are held stable through ACCESS. Input changes during SETUP/ACCESS have no effect on the current transfer.
- Slave select: paddr[AW-1]=0 → slave 1; 1 → slave 2.
- Slaves: each holds 2^(AW-1) words of DW bits, indexed by paddr[AW-2:0]. All words are cleared to 0 on reset.
- Write: the slave memory word is updated at the edge ending ACCESS when pready=1.
- Read: prdata of the selected slave is muxed to the master. apb_read_data_out is loaded at the edge ending ACCESS when pready=1 for a read.
- apb_read_data_out holds its value across writes and idle cycles.
- Reset values: FSM=IDLE, all psel/penable=0, apb_read_data_out=0, all memory=0.
- Reset asserted mid-transfer aborts it immediately: no memory write, and apb_read_data_out is cleared.

## Timing
- Zero-wait-state slaves (default): pready=1 throughout ACCESS.
- Single transfer: request sampled at edge N (IDLE→SETUP); SETUP is cycle N+1; ACCESS is cycle N+2; completion at edge N+3.
- Read latency: apb_read_data_out is valid 3 edges after transfer is sampled.
- Back-to-back transfers: sustained throughput is one transfer per 2 cycles (SETUP/ACCESS alternating) while transfer stays high.
- Read after write to the same address in consecutive transfers returns the newly written data.
- Address wrap: the highest index (all ones in AW-2:0) is valid; there is no out-of-range case.

## Configuration
- APB_WAIT_STATE_EN
  - Defined: each slave holds pready=0 for the first ACCESS cycle and 1 for the second. Every transfer takes 3 cycles, and read latency becomes 4 edges.
  - Undefined: pready is tied 1 (zero wait states).

## Test plan
- Reset: hold presetn=0 for 2 cycles → apb_read_data_out=0, FSM IDLE. Then a read of 0x005 → returns 0x00.
- Write/read slave 1: write 0xA5 to 0x010, then read 0x010 → apb_read_data_out=0xA5, 3 edges after the read request.
- Slave decode: write 0x3C to 0x110 and 0xC3 to 0x010; read 0x110 → 0x3C; read 0x010 → 0xC3.
- Back-to-back: transfer held high for 4 writes to 0x1FF, 0x000, 0x0FF, 0x100 (data 0x11, 0x22, 0x33, 0x44) → one completion every 2 cycles; read-back returns those values.
- Reset mid-transfer: presetn drops during ACCESS of a write of 0x77 to 0x020 → a later read of 0x020 returns 0x00.
- With APB_WAIT_STATE_EN: write 0x5A to 0x101, then read it → ACCESS lasts 2 cycles and 0x5A appears 4 edges after the read request.
